// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the pipeline hazard controller
package pipe_pkg;

  // ALU operand mux selects
  localparam logic [1:0] BYP_XM = 2'd0;
  localparam logic [1:0] BYP_WB = 2'd1;
  localparam logic [1:0] BYP_RF = 2'd2;

  // Default multdiv latency in cycles
  localparam int MD_LAT_DEF = 32;

  // Multdiv tracker states
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_tracker.sv
// rtl/md_tracker.sv - multdiv occupancy FSM with latency down-counter
module md_tracker
  import pipe_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int MD_LAT = MD_LAT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start,
  input  logic [REG_W-1:0] i_rd,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_cnt,
  output logic [REG_W-1:0] o_rd
);

  md_state_e        r_state, w_state_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic [REG_W-1:0] r_rd, w_rd_nxt;

  // State, counter and destination registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd    <= w_rd_nxt;
    end
  end

  // Next-state: a start in IDLE loads the latency; a start while busy is dropped
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_nxt    = r_rd;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_MD_BUSY;
          w_cnt_nxt   = 8'(MD_LAT - 1);
          w_rd_nxt    = i_rd;
        end
      end
      ST_MD_BUSY: begin
        if (r_cnt == 8'd0) begin
          o_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state == ST_MD_BUSY);
  assign o_cnt  = r_cnt;
  assign o_rd   = r_rd;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, flush and bypass control for a 5-stage pipeline
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int MD_LAT = MD_LAT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  input  logic             fd_is_md,
  input  logic [REG_W-1:0] dx_rs,
  input  logic [REG_W-1:0] dx_rt,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             dx_wr,
  input  logic             dx_is_lw,
  input  logic             dx_is_md,
  input  logic [REG_W-1:0] xm_rd,
  input  logic             xm_wr,
  input  logic [REG_W-1:0] mw_rd,
  input  logic             mw_wr,
  input  logic             branch_taken,
  output logic             stall_f,
  output logic             bubble_dx,
  output logic             flush,
  output logic [1:0]       byp_a_sel,
  output logic [1:0]       byp_b_sel,
  output logic             md_busy,
  output logic             md_done,
  output logic [REG_W-1:0] md_rd,
  output logic [31:0]      stall_cycles
);

  logic             w_md_busy, w_md_done;
  logic [7:0]       w_md_cnt;
  logic             w_load_use, w_md_dep, w_md_slot;
  logic [31:0]      r_stall_cycles;

  md_tracker #(.REG_W(REG_W), .MD_LAT(MD_LAT)) u_md_tracker (
    .clock   (clock),
    .reset   (reset),
    .i_start (dx_is_md),
    .i_rd    (dx_rd),
    .o_busy  (w_md_busy),
    .o_done  (w_md_done),
    .o_cnt   (w_md_cnt),
    .o_rd    (md_rd)
  );

  // Register 0 is hardwired, so it never matches as a producer
  assign w_load_use = dx_is_lw & dx_wr & (dx_rd != '0) &
                      ((fd_uses_rs & (fd_rs == dx_rd)) | (fd_uses_rt & (fd_rt == dx_rd)));

  assign w_md_dep = w_md_busy &
                    ((fd_uses_rs & (fd_rs != '0) & (fd_rs == md_rd)) |
                     (fd_uses_rt & (fd_rt != '0) & (fd_rt == md_rd)) |
                     fd_is_md);

  // One cycle before completion the X slot must be emptied for the result
  assign w_md_slot = w_md_busy & (w_md_cnt == 8'd1);

  // Stall/flush arbitration: reset and taken branches override every stall
  always_comb begin
    stall_f   = 1'b0;
    bubble_dx = 1'b0;
    flush     = 1'b0;
    if (reset || branch_taken) begin
      flush = 1'b1;
    end else if (w_load_use || w_md_dep || w_md_slot) begin
      stall_f   = 1'b1;
      bubble_dx = 1'b1;
    end
  end

  // Operand bypass selects, X/M has priority over writeback
  always_comb begin
    byp_a_sel = BYP_RF;
    byp_b_sel = BYP_RF;
    if (!reset) begin
      if (xm_wr && xm_rd != '0 && xm_rd == dx_rs)      byp_a_sel = BYP_XM;
      else if (mw_wr && mw_rd != '0 && mw_rd == dx_rs) byp_a_sel = BYP_WB;
      if (xm_wr && xm_rd != '0 && xm_rd == dx_rt)      byp_b_sel = BYP_XM;
      else if (mw_wr && mw_rd != '0 && mw_rd == dx_rt) byp_b_sel = BYP_WB;
    end
  end

  // Saturating count of stalled fetch cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (stall_f && r_stall_cycles != 32'hFFFF_FFFF) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign md_busy      = w_md_busy & ~reset;
  assign md_done      = w_md_done & ~reset;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] fd_rs, fd_rt, dx_rs, dx_rt, dx_rd, xm_rd, mw_rd;
  logic       fd_uses_rs, fd_uses_rt, fd_is_md;
  logic       dx_wr, dx_is_lw, dx_is_md, xm_wr, mw_wr, branch_taken;
  logic       stall_f, bubble_dx, flush, md_busy, md_done;
  logic [1:0] byp_a_sel, byp_b_sel;
  logic [4:0] md_rd;
  logic [31:0] stall_cycles;

  int ntests = 0;
  int nfail  = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.REG_W(5), .MD_LAT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .fd_rs        (fd_rs),
    .fd_rt        (fd_rt),
    .fd_uses_rs   (fd_uses_rs),
    .fd_uses_rt   (fd_uses_rt),
    .fd_is_md     (fd_is_md),
    .dx_rs        (dx_rs),
    .dx_rt        (dx_rt),
    .dx_rd        (dx_rd),
    .dx_wr        (dx_wr),
    .dx_is_lw     (dx_is_lw),
    .dx_is_md     (dx_is_md),
    .xm_rd        (xm_rd),
    .xm_wr        (xm_wr),
    .mw_rd        (mw_rd),
    .mw_wr        (mw_wr),
    .branch_taken (branch_taken),
    .stall_f      (stall_f),
    .bubble_dx    (bubble_dx),
    .flush        (flush),
    .byp_a_sel    (byp_a_sel),
    .byp_b_sel    (byp_b_sel),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .md_rd        (md_rd),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    fd_rs = '0; fd_rt = '0; fd_uses_rs = 0; fd_uses_rt = 0; fd_is_md = 0;
    dx_rs = '0; dx_rt = '0; dx_rd = '0; dx_wr = 0; dx_is_lw = 0; dx_is_md = 0;
    xm_rd = '0; xm_wr = 0; mw_rd = '0; mw_wr = 0; branch_taken = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    xm_wr = 1; xm_rd = 5; dx_rs = 5;
    tick();
    settle();
    chk("rst_flush", flush, 1);
    chk("rst_stall", stall_f, 0);
    chk("rst_bubble", bubble_dx, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_byp_a", byp_a_sel, 2);
    chk("rst_byp_b", byp_b_sel, 2);
    tick();
    chk("rst_cnt", stall_cycles, 0);
    chk("rst_md_rd", md_rd, 0);

    // Bypass priority
    reset = 1'b0;
    clear_inputs();
    tick();
    chk("idle_flush", flush, 0);
    xm_wr = 1; xm_rd = 5; mw_wr = 1; mw_rd = 5; dx_rs = 5; dx_rt = 5;
    settle();
    chk("byp_a_xm", byp_a_sel, 0);
    chk("byp_b_xm", byp_b_sel, 0);
    xm_wr = 0;
    settle();
    chk("byp_a_wb", byp_a_sel, 1);
    dx_rs = 0;
    settle();
    chk("byp_a_rf_r0", byp_a_sel, 2);
    dx_rt = 6;
    settle();
    chk("byp_b_rf", byp_b_sel, 2);
    xm_wr = 1; xm_rd = 0; mw_wr = 1; mw_rd = 0; dx_rs = 0; dx_rt = 0;
    settle();
    chk("byp_a_r0_all", byp_a_sel, 2);
    clear_inputs();

    // Load-use: r0 destination never hazards
    dx_is_lw = 1; dx_wr = 1; dx_rd = 0; fd_uses_rt = 1; fd_rt = 0;
    settle();
    chk("lu_r0_stall", stall_f, 0);
    dx_rd = 3; fd_rt = 3;
    settle();
    chk("lu_stall", stall_f, 1);
    chk("lu_bubble", bubble_dx, 1);
    tick();
    dx_is_lw = 0; dx_wr = 0; dx_rd = 0;
    settle();
    chk("lu_stall_gone", stall_f, 0);
    chk("lu_bubble_gone", bubble_dx, 0);
    chk("lu_cnt", stall_cycles, 1);
    clear_inputs();

    // Branch beats load-use
    dx_is_lw = 1; dx_wr = 1; dx_rd = 3; fd_uses_rt = 1; fd_rt = 3; branch_taken = 1;
    settle();
    chk("br_flush", flush, 1);
    chk("br_stall", stall_f, 0);
    chk("br_bubble", bubble_dx, 0);
    tick();
    clear_inputs();
    settle();
    chk("br_cnt", stall_cycles, 1);

    // Multdiv, independent F/D instruction (fd_rs=8)
    dx_is_md = 1; dx_rd = 7;
    settle();
    chk("md0_busy", md_busy, 0);
    chk("md0_stall", stall_f, 0);
    tick();
    clear_inputs();
    fd_uses_rs = 1; fd_rs = 8;
    settle();
    chk("md1_busy", md_busy, 1);
    chk("md1_rd", md_rd, 7);
    chk("md1_stall", stall_f, 0);
    chk("md1_done", md_done, 0);
    tick();
    chk("md2_busy", md_busy, 1);
    chk("md2_stall", stall_f, 0);
    tick();
    chk("md3_busy", md_busy, 1);
    chk("md3_stall_slot", stall_f, 1);
    chk("md3_bubble_slot", bubble_dx, 1);
    chk("md3_done", md_done, 0);
    tick();
    dx_is_md = 1; dx_rd = 9;
    settle();
    chk("md4_busy", md_busy, 1);
    chk("md4_done", md_done, 1);
    chk("md4_stall", stall_f, 0);
    tick();
    clear_inputs();
    settle();
    chk("md5_busy", md_busy, 0);
    chk("md5_done", md_done, 0);
    chk("md5_rd_kept", md_rd, 7);
    chk("md5_cnt", stall_cycles, 2);

    // Multdiv, dependent F/D instruction (fd_rs=7)
    dx_is_md = 1; dx_rd = 7;
    tick();
    clear_inputs();
    fd_uses_rs = 1; fd_rs = 7;
    settle();
    chk("dep1_stall", stall_f, 1);
    chk("dep1_bubble", bubble_dx, 1);
    tick();
    chk("dep2_stall", stall_f, 1);
    tick();
    chk("dep3_stall", stall_f, 1);
    chk("dep3_done", md_done, 0);
    tick();
    fd_uses_rs = 0;
    settle();
    chk("dep4_done", md_done, 1);
    chk("dep4_stall", stall_f, 0);
    tick();
    chk("dep5_busy", md_busy, 0);
    chk("dep5_cnt", stall_cycles, 5);

    // fd_is_md stalls while busy
    dx_is_md = 1; dx_rd = 4;
    tick();
    clear_inputs();
    fd_is_md = 1;
    settle();
    chk("mdmd_stall", stall_f, 1);
    fd_is_md = 0;
    tick();

    // Reset mid-operation aborts without a done pulse
    chk("abort_busy_pre", md_busy, 1);
    reset = 1'b1;
    settle();
    chk("abort_busy_rst", md_busy, 0);
    chk("abort_done_rst", md_done, 0);
    chk("abort_flush_rst", flush, 1);
    tick();
    reset = 1'b0;
    settle();
    chk("abort_busy", md_busy, 0);
    chk("abort_cnt", stall_cycles, 0);
    chk("abort_md_rd", md_rd, 0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_done", md_done, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
